// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer driving
// datapath strobes from the current state, the latched opcode class and mem_ready.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic             pc_source,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_R      = 3'd0,
        C_LOAD   = 3'd1,
        C_STORE  = 3'd2,
        C_BRANCH = 3'd3,
        C_OTHER  = 3'd4
    } cls_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic cls_t classify(input logic [6:0] op);
        case (op)
            7'b0110011: classify = C_R;
            7'b0000011: classify = C_LOAD;
            7'b0100011: classify = C_STORE;
            7'b1100011: classify = C_BRANCH;
            default:    classify = C_OTHER;
        endcase
    endfunction

    state_t           state_q, state_nxt;
    cls_t             cls_q, cls_nxt, dec_cls;
    logic [CNT_W-1:0] retired_q;
    logic             retire;

    logic       pc_write_c, pc_write_cond_c, ir_write_c, i_or_d_c;
    logic       mem_read_c, mem_write_c, reg_write_c, mem_to_reg_c;
    logic       alu_src_a_c, pc_source_c, illegal_c;
    logic [1:0] alu_src_b_c, alu_op_c;

    assign dec_cls = classify(opcode);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            cls_q     <= C_OTHER;
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            cls_q   <= cls_nxt;
            if (retire)
                retired_q <= retired_q + CNT_ONE;
        end
    end

    always_comb begin
        state_nxt       = FETCH;
        cls_nxt         = cls_q;
        retire          = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        reg_write_c     = 1'b0;
        mem_to_reg_c    = 1'b0;
        alu_src_a_c     = 1'b0;
        pc_source_c     = 1'b0;
        illegal_c       = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;

        case (state_q)
            FETCH: begin
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'b01;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_nxt  = DECODE;
                end else begin
                    state_nxt  = FETCH;
                end
            end
            DECODE: begin
                // ALU precomputes the branch target while the class is latched
                alu_src_b_c = 2'b10;
                cls_nxt     = dec_cls;
                if (dec_cls == C_OTHER) begin
                    illegal_c = 1'b1;
                    state_nxt = FETCH;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                alu_src_a_c = 1'b1;
                case (cls_q)
                    C_R: begin
                        alu_op_c  = 2'b10;
                        state_nxt = WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_b_c = 2'b10;
                        state_nxt   = MEM;
                    end
                    C_BRANCH: begin
                        alu_op_c        = 2'b01;
                        pc_write_cond_c = 1'b1;
                        pc_source_c     = 1'b1;
                        retire          = 1'b1;
                    end
                    default: state_nxt = FETCH;
                endcase
            end
            MEM: begin
                i_or_d_c    = 1'b1;
                mem_read_c  = (cls_q == C_LOAD);
                mem_write_c = (cls_q == C_STORE);
                if (cls_q != C_LOAD && cls_q != C_STORE) begin
                    state_nxt = FETCH;
                end else if (!mem_ready) begin
                    state_nxt = MEM;
                end else if (cls_q == C_LOAD) begin
                    state_nxt = WB;
                end else begin
                    retire = 1'b1;
                end
            end
            WB: begin
                if (cls_q == C_R || cls_q == C_LOAD) begin
                    reg_write_c  = 1'b1;
                    mem_to_reg_c = (cls_q == C_LOAD);
                    retire       = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Outputs are forced low while reset is held, without waiting for a clock
    assign pc_write      = pc_write_c      & rst_n;
    assign pc_write_cond = pc_write_cond_c & rst_n;
    assign ir_write      = ir_write_c      & rst_n;
    assign i_or_d        = i_or_d_c        & rst_n;
    assign mem_read      = mem_read_c      & rst_n;
    assign mem_write     = mem_write_c     & rst_n;
    assign reg_write     = reg_write_c     & rst_n;
    assign mem_to_reg    = mem_to_reg_c    & rst_n;
    assign alu_src_a     = alu_src_a_c     & rst_n;
    assign pc_source     = pc_source_c     & rst_n;
    assign illegal       = illegal_c       & rst_n;
    assign alu_src_b     = alu_src_b_c     & {2{rst_n}};
    assign alu_op        = alu_op_c        & {2{rst_n}};
    assign state         = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected state, control
// word and retire count are queued with the stimulus and compared at negedge.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0110011;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, mem_to_reg, alu_src_a, pc_source, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [2:0]  state;
    logic [31:0] retired;

    logic        rst4_n = 1'b0;
    logic [6:0]  opcode4 = 7'b1100011;
    logic        pw4, pwc4, irw4, iod4, mr4, mw4, rw4, mtr4, asa4, pcs4, ill4;
    logic [1:0]  asb4, aop4;
    logic [2:0]  state4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .pc_source(pc_source), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .illegal(illegal), .state(state), .retired(retired)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .opcode(opcode4), .mem_ready(1'b1),
        .pc_write(pw4), .pc_write_cond(pwc4), .ir_write(irw4),
        .i_or_d(iod4), .mem_read(mr4), .mem_write(mw4),
        .reg_write(rw4), .mem_to_reg(mtr4), .alu_src_a(asa4),
        .pc_source(pcs4), .alu_src_b(asb4), .alu_op(aop4),
        .illegal(ill4), .state(state4), .retired(retired4)
    );

    // Control word: pcw pcc irw iod mr mw rw mtr asa pcs asb[1:0] aop[1:0] ill
    logic [14:0] act_ctl;
    assign act_ctl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                      reg_write, mem_to_reg, alu_src_a, pc_source, alu_src_b, alu_op, illegal};

    localparam logic [14:0] C_ZERO  = 15'b0_0_0_0_0_0_0_0_0_0_00_00_0;
    localparam logic [14:0] C_FRDY  = 15'b1_0_1_0_1_0_0_0_0_0_01_00_0;
    localparam logic [14:0] C_FWAIT = 15'b0_0_0_0_1_0_0_0_0_0_01_00_0;
    localparam logic [14:0] C_DEC   = 15'b0_0_0_0_0_0_0_0_0_0_10_00_0;
    localparam logic [14:0] C_DILL  = 15'b0_0_0_0_0_0_0_0_0_0_10_00_1;
    localparam logic [14:0] C_EXR   = 15'b0_0_0_0_0_0_0_0_1_0_00_10_0;
    localparam logic [14:0] C_EXLS  = 15'b0_0_0_0_0_0_0_0_1_0_10_00_0;
    localparam logic [14:0] C_EXBR  = 15'b0_1_0_0_0_0_0_0_1_1_00_01_0;
    localparam logic [14:0] C_MEMLD = 15'b0_0_0_1_1_0_0_0_0_0_00_00_0;
    localparam logic [14:0] C_MEMST = 15'b0_0_0_1_0_1_0_0_0_0_00_00_0;
    localparam logic [14:0] C_WBLD  = 15'b0_0_0_0_0_0_1_1_0_0_00_00_0;
    localparam logic [14:0] C_WBR   = 15'b0_0_0_0_0_0_1_0_0_0_00_00_0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ILL = 7'b0010011;

    typedef struct {
        logic        rdy;
        logic [6:0]  opc;
        logic [2:0]  st;
        logic [14:0] ctl;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  wq[$];
    logic [31:0] exp_ret = 0;
    int          nerr = 0;
    int          nchk = 0;

    task automatic push(input logic rdy, input logic [6:0] opc,
                        input logic [2:0] st, input logic [14:0] ctl);
        exp_t e;
        e.rdy = rdy; e.opc = opc; e.st = st; e.ctl = ctl; e.ret = exp_ret;
        sb.push_back(e);
    endtask

    // Advance one cycle: drive inputs just after the edge, return at negedge
    task automatic drive(input logic rdy, input logic [6:0] opc);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode    = opc;
        @(negedge clk);
    endtask

    task automatic push_r(input logic [6:0] dummy);
        push(1'b1, OP_R, 3'd0, C_FRDY);
        push(1'b1, OP_R, 3'd1, C_DEC);
        push(1'b1, OP_R, 3'd2, C_EXR);
        push(1'b1, OP_R, 3'd4, C_WBR);
        exp_ret = exp_ret + 1 + {25'd0, dummy & 7'd0};
    endtask

    task automatic test_reset;
        exp_t e;
        for (int i = 0; i < 3; i++) push(1'b1, OP_R, 3'd0, C_ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL reset_hold: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        nchk++;
        if ({state, act_ctl, retired} !== {3'd0, C_FWAIT, 32'd0}) begin
            nerr++;
            $display("FAIL first_fetch: state=%0d ctl=%b ret=%0d want state=0 ctl=%b ret=0",
                     state, act_ctl, retired, C_FWAIT);
        end
    endtask

    task automatic test_rtype;
        exp_t e;
        push(1'b0, OP_R, 3'd0, C_FWAIT);
        push(1'b0, OP_R, 3'd0, C_FWAIT);
        push_r(7'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL rtype: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
    endtask

    task automatic test_load_wait;
        exp_t e;
        push(1'b1, OP_LD, 3'd0, C_FRDY);
        push(1'b1, OP_LD, 3'd1, C_DEC);
        push(1'b1, OP_LD, 3'd2, C_EXLS);
        for (int i = 0; i < 3; i++) push(1'b0, OP_LD, 3'd3, C_MEMLD);
        push(1'b1, OP_LD, 3'd3, C_MEMLD);
        push(1'b1, OP_LD, 3'd4, C_WBLD);
        exp_ret = exp_ret + 1;
        push(1'b0, OP_LD, 3'd0, C_FWAIT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL load_wait: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
    endtask

    task automatic test_store_branch;
        exp_t e;
        push(1'b1, OP_ST, 3'd0, C_FRDY);
        push(1'b1, OP_ST, 3'd1, C_DEC);
        push(1'b1, OP_ST, 3'd2, C_EXLS);
        push(1'b1, OP_ST, 3'd3, C_MEMST);
        exp_ret = exp_ret + 1;
        push(1'b1, OP_BR, 3'd0, C_FRDY);
        push(1'b1, OP_BR, 3'd1, C_DEC);
        push(1'b1, OP_BR, 3'd2, C_EXBR);
        exp_ret = exp_ret + 1;
        push(1'b0, OP_BR, 3'd0, C_FWAIT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL store_branch: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
    endtask

    task automatic test_illegal;
        exp_t e;
        push(1'b1, OP_ILL, 3'd0, C_FRDY);
        push(1'b1, OP_ILL, 3'd1, C_DILL);
        push(1'b0, OP_ILL, 3'd0, C_FWAIT);
        push(1'b0, OP_ILL, 3'd0, C_FWAIT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL illegal: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        push(1'b1, OP_ST, 3'd0, C_FRDY);
        push(1'b1, OP_ST, 3'd1, C_DEC);
        push(1'b1, OP_ST, 3'd2, C_EXLS);
        push(1'b0, OP_ST, 3'd3, C_MEMST);
        push(1'b0, OP_ST, 3'd3, C_MEMST);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL mem_wait: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        exp_ret = 0;
        nchk++;
        if ({state, act_ctl, retired} !== {3'd0, C_ZERO, 32'd0}) begin
            nerr++;
            $display("FAIL async_abort: state=%0d ctl=%b ret=%0d want state=0 ctl=0 ret=0",
                     state, act_ctl, retired);
        end
        for (int i = 0; i < 2; i++) push(1'b1, OP_ST, 3'd0, C_ZERO);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL abort_hold: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        nchk++;
        if ({state, act_ctl, retired} !== {3'd0, C_FWAIT, 32'd0}) begin
            nerr++;
            $display("FAIL restart_fetch: state=%0d ctl=%b ret=%0d want state=0 ctl=%b ret=0",
                     state, act_ctl, retired, C_FWAIT);
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        push_r(7'd0);
        push(1'b1, OP_LD, 3'd0, C_FRDY);
        push(1'b1, OP_LD, 3'd1, C_DEC);
        push(1'b1, OP_LD, 3'd2, C_EXLS);
        push(1'b1, OP_LD, 3'd3, C_MEMLD);
        push(1'b1, OP_LD, 3'd4, C_WBLD);
        exp_ret = exp_ret + 1;
        push(1'b1, OP_ILL, 3'd0, C_FRDY);
        push(1'b1, OP_ILL, 3'd1, C_DILL);
        push(1'b1, OP_BR, 3'd0, C_FRDY);
        push(1'b1, OP_BR, 3'd1, C_DEC);
        push(1'b1, OP_BR, 3'd2, C_EXBR);
        exp_ret = exp_ret + 1;
        push(1'b0, OP_BR, 3'd0, C_FWAIT);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.rdy, e.opc);
            nchk++;
            if ({state, act_ctl, retired} !== {e.st, e.ctl, e.ret}) begin
                nerr++;
                $display("FAIL back_to_back: state=%0d ctl=%b ret=%0d want state=%0d ctl=%b ret=%0d",
                         state, act_ctl, retired, e.st, e.ctl, e.ret);
            end
        end
    endtask

    task automatic test_wrap;
        logic [3:0] w;
        @(posedge clk);
        #1;
        rst4_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            wq.push_back(i[3:0]);
            repeat (3) @(posedge clk);
            #1;
            w = wq.pop_front();
            nchk++;
            if (retired4 !== w) begin
                nerr++;
                $display("FAIL wrap_count: retire %0d got retired=%0d want %0d", i, retired4, w);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_rtype;
        test_load_wait;
        test_store_branch;
        test_illegal;
        test_reset_mid;
        test_back_to_back;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
